pipe_ctrl: RTL and testbench

Central sequencing controller for the five-stage RISC pipeline (fetch, decode, execute, memory, writeback). It generates per-stage latch enables and bubble/flush controls, and resolves three hazard sources:
- load-use data hazards that forwarding cannot cover;
- taken branches resolved in EX;
- multi-cycle data-memory accesses, using a req/ack handshake with a watchdog.

It also owns the sticky halted and fault status and a stall performance counter. It sits beside the stage modules and the forwarding unit, with the stage modules gated by its outputs.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/mem_watchdog.sv | 30 +++
 rtl/pipe_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  // Controller FSM states; the encoding is also visible on dbg_state.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  // Architectural zero register never creates a dependency.
  localparam logic [4:0]  REG_ZERO      = 5'd0;
  // Stall counter sticks here instead of wrapping.
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_watchdog.sv
// Watchdog for multi-cycle data-memory accesses. Counts MEM_WAIT cycles
// without an ack; timeout fires on the increment that reaches MEM_TIMEOUT.
module mem_watchdog #(
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk1,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  logic [TO_W-1:0] cnt_q;

  // Timeout is qualified by inc so an ack in the same cycle (inc low) wins.
  assign timeout = inc && (cnt_q == TO_W'(MEM_TIMEOUT - 1));

  // Wait-cycle counter: clear has priority over increment.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencing controller for the five-stage pipeline: latch enables,
// bubble/flush controls, hazard resolution, halt/fault status, stall counter.
//
// Memory handshake: mem_req is high while EX/MEM holds an access (mem_valid)
// and the controller is able to issue it. The access completes in the cycle
// where mem_req and mem_ack are both high; until then the whole pipeline holds
// and a bubble is pushed into MEM/WB.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs2,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic            ex_halt,
  input  logic            mem_valid,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            mem_wb_flush,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_target,
  output logic            halted,
  output logic            fault,
  output logic [15:0]     stall_cnt,
  output logic [1:0]      dbg_state
);

  state_t      state_q, state_d;
  logic        halted_q, fault_q;
  logic [15:0] stall_cnt_q;
  logic        load_use;
  logic        stall_path, run_path, drain_path, lu_active, stall_active;
  logic        wd_inc, wd_clr, wd_timeout;

  // Load-use hazard: a load in EX writes a register the IF/ID instruction reads.
  assign load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Watchdog only runs in MEM_WAIT while the ack is still missing.
  assign wd_inc = (state_q == ST_MEM_WAIT) && !mem_ack;
  assign wd_clr = !wd_inc;

  mem_watchdog #(
    .TO_W        (TO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk1    (clk1),
    .rst     (rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .timeout (wd_timeout)
  );

  // Next state and stage controls; priority memory stall > halt > branch > load-use.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    pc_load      = 1'b0;
    pc_target    = '0;
    stall_path   = 1'b0;
    run_path     = 1'b0;
    drain_path   = 1'b0;
    lu_active    = 1'b0;

    // Pick which control regime applies this cycle.
    unique case (state_q)
      ST_RUN: begin
        mem_req = mem_valid;
        if (mem_valid && !mem_ack) begin
          stall_path = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else begin
          run_path = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        mem_req = mem_valid;
        if (!mem_ack) begin
          stall_path = 1'b1;
          if (wd_timeout) state_d = ST_FAULT;
        end else if (halted_q) begin
          // Stall happened while draining after HALT: go back to draining.
          drain_path = 1'b1;
          state_d    = ST_HALTED;
        end else begin
          // Resume cycle: EX is re-evaluated, so a held branch is taken now.
          run_path = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_HALTED: begin
        mem_req = mem_valid;
        if (mem_valid && !mem_ack) begin
          stall_path = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else begin
          drain_path = 1'b1;
        end
      end
      ST_FAULT: begin
        // Everything frozen and no memory traffic until reset.
      end
      default: state_d = ST_RUN;
    endcase

    if (stall_path) begin
      mem_wb_flush = 1'b1;
    end

    if (run_path) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_halt) begin
        drain_path = 1'b1;
        state_d    = ST_HALTED;
      end else if (ex_br_taken) begin
        pc_load     = 1'b1;
        pc_target   = ex_br_target;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        lu_active   = 1'b1;
      end
    end

    // Drain: front stages frozen, older instructions keep moving.
    if (drain_path) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      id_ex_flush = 1'b1;
    end

    // Every output reads zero while reset is held.
    if (rst) begin
      mem_req      = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      pc_load      = 1'b0;
      pc_target    = '0;
      stall_path   = 1'b0;
      lu_active    = 1'b0;
      state_d      = ST_RUN;
    end
  end

  assign stall_active = stall_path || lu_active;

  // State register, sticky status flags and saturating stall counter.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALTED) halted_q <= 1'b1;
      if (state_d == ST_FAULT)  fault_q  <= 1'b1;
      if (stall_active && (stall_cnt_q != STALL_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign halted    = halted_q;
  assign fault     = fault_q;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an expected-value queue.
module tb_pipe_ctrl;

  localparam int XLEN = 32;
  localparam int W    = 60;

  logic            clk1;
  logic            rst;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_uses_rs2, ex_is_load, ex_br_taken, ex_halt;
  logic [XLEN-1:0] ex_br_target;
  logic            mem_valid, mem_ack;
  logic            mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic            if_id_flush, id_ex_flush, mem_wb_flush, pc_load;
  logic [XLEN-1:0] pc_target;
  logic            halted, fault;
  logic [15:0]     stall_cnt;
  logic [1:0]      dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_vec;
  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.XLEN(XLEN), .TO_W(8), .MEM_TIMEOUT(4)) dut (
    .clk1(clk1), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_ack(mem_ack), .mem_req(mem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .pc_load(pc_load), .pc_target(pc_target),
    .halted(halted), .fault(fault), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // Clock/reset block
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  assign obs_vec = {mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_flush, pc_load, halted, fault,
                    pc_target, stall_cnt};

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, mem_wb}
  function automatic logic [W-1:0] ev(input logic req, input logic [4:0] en,
                                      input logic [2:0] fl, input logic pl,
                                      input logic [31:0] tgt, input logic h,
                                      input logic f, input logic [15:0] sc);
    return {req, en, fl, pl, h, f, tgt, sc};
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_rd = 5'd0;
    ex_br_taken = 1'b0; ex_br_target = '0; ex_halt = 1'b0;
    mem_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic drive_mem(input logic v, input logic a);
    idle_inputs();
    mem_valid = v; mem_ack = a;
  endtask

  // Scoreboard
  task automatic compare_now(input string tag);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs_vec);
    end else begin
      e = exp_q.pop_front();
      assert (obs_vec === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs_vec, e);
      end
    end
  endtask

  task automatic tick_check(input string tag);
    @(negedge clk1);
    compare_now(tag);
    @(posedge clk1);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [1:0] e);
    total++;
    assert (dbg_state === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, e);
    end
  endtask

  initial begin
    // Reset with noisy inputs: every output must still read zero.
    idle_inputs();
    rst = 1'b1;
    ex_br_taken = 1'b1; ex_br_target = 32'h1234; mem_valid = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    #2;
    exp_q.push_back(ev(0, 5'b00000, 3'b000, 0, 32'h0, 0, 0, 16'd0));
    compare_now("reset_outputs");
    check_state("reset_state", 2'd0);
    @(negedge clk1); rst = 1'b0; idle_inputs();
    @(posedge clk1); #1;

    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd0));
    tick_check("idle_run");

    // Load-use via rs1: one-cycle bubble
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    exp_q.push_back(ev(0, 5'b00111, 3'b010, 0, 32'h0, 0, 0, 16'd0));
    tick_check("lu_rs1");
    idle_inputs();
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd1));
    tick_check("lu_after");

    // Load-use via rs2, then rs2 not used, then rd = x0
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd1;
    exp_q.push_back(ev(0, 5'b00111, 3'b010, 0, 32'h0, 0, 0, 16'd1));
    tick_check("lu_rs2");
    id_uses_rs2 = 1'b0;
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd2));
    tick_check("lu_rs2_unused");
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd2));
    tick_check("lu_rd_zero");

    // Taken branch overrides a simultaneous load-use
    idle_inputs();
    ex_br_taken = 1'b1; ex_br_target = 32'h0000_0040;
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    exp_q.push_back(ev(0, 5'b11111, 3'b110, 1, 32'h40, 0, 0, 16'd2));
    tick_check("branch_over_lu");
    idle_inputs();
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd2));
    tick_check("branch_after");

    // Memory access with 3 wait cycles and a branch held in EX
    drive_mem(1, 0); ex_br_taken = 1'b1; ex_br_target = 32'h80;
    exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 0, 0, 16'd2));
    tick_check("mem_wait1");
    exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 0, 0, 16'd3));
    tick_check("mem_wait2");
    exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 0, 0, 16'd4));
    tick_check("mem_wait3");
    mem_ack = 1'b1;
    exp_q.push_back(ev(1, 5'b11111, 3'b110, 1, 32'h80, 0, 0, 16'd5));
    tick_check("mem_resume_branch");

    // Zero-wait access
    drive_mem(1, 1);
    exp_q.push_back(ev(1, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd5));
    tick_check("mem_zero_wait");

    // Ack lands on the cycle the watchdog would expire
    drive_mem(1, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 0, 0, 16'(5 + i)));
      tick_check("ack_race_wait");
    end
    mem_ack = 1'b1;
    exp_q.push_back(ev(1, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd9));
    tick_check("ack_race_resume");
    idle_inputs();
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd9));
    tick_check("ack_race_no_fault");

    // HALT then a store draining through MEM
    ex_halt = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h99;
    exp_q.push_back(ev(0, 5'b00011, 3'b010, 0, 32'h0, 0, 0, 16'd9));
    tick_check("halt_enter");
    drive_mem(1, 0);
    exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 1, 0, 16'd9));
    tick_check("drain_store_wait");
    check_state("drain_in_mem_wait", 2'd1);
    mem_ack = 1'b1;
    exp_q.push_back(ev(1, 5'b00011, 3'b010, 0, 32'h0, 1, 0, 16'd10));
    tick_check("drain_store_ack");
    idle_inputs(); ex_br_taken = 1'b1; ex_br_target = 32'h44;
    exp_q.push_back(ev(0, 5'b00011, 3'b010, 0, 32'h0, 1, 0, 16'd10));
    tick_check("halted_hold");

    // Asynchronous reset in the middle of MEM_WAIT
    drive_mem(1, 0);
    exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 1, 0, 16'd10));
    tick_check("pre_rst_wait");
    rst = 1'b1;
    #1;
    exp_q.push_back(ev(0, 5'b00000, 3'b000, 0, 32'h0, 0, 0, 16'd0));
    compare_now("rst_mid_wait");
    @(negedge clk1); rst = 1'b0; idle_inputs();
    @(posedge clk1); #1;
    check_state("post_rst_state", 2'd0);
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd0));
    tick_check("post_rst_run");

    // Watchdog timeout: ack never comes
    drive_mem(1, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ev(1, 5'b00000, 3'b001, 0, 32'h0, 0, 0, 16'(i)));
      tick_check("timeout_wait");
    end
    exp_q.push_back(ev(0, 5'b00000, 3'b000, 0, 32'h0, 0, 1, 16'd5));
    tick_check("fault_enter");
    check_state("fault_state", 2'd3);
    mem_ack = 1'b1; ex_br_taken = 1'b1;
    exp_q.push_back(ev(0, 5'b00000, 3'b000, 0, 32'h0, 0, 1, 16'd5));
    tick_check("fault_hold");

    // Reset clears fault
    rst = 1'b1;
    #1;
    exp_q.push_back(ev(0, 5'b00000, 3'b000, 0, 32'h0, 0, 0, 16'd0));
    compare_now("rst_in_fault");
    @(negedge clk1); rst = 1'b0; idle_inputs();
    @(posedge clk1); #1;
    exp_q.push_back(ev(0, 5'b11111, 3'b000, 0, 32'h0, 0, 0, 16'd0));
    tick_check("post_fault_run");

    // Final report
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL leftover_expect observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
